data_mem_ctrl: RTL and testbench

Parametrised single-port data memory with a handshake front end, byte-lane write enables, a configurable read latency and a hardware clear sequencer that zeroes every word after reset or on request. It is the next-generation data memory for the processor datapath, sitting between the load/store unit and on-chip storage. A bounds checker flags accesses at or beyond DEPTH.

---
 rtl/data_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with a req/ready front end, byte-lane writes,
// 1- or 2-cycle read latency and a sequencer that zeroes every word after
// reset or on clear_req. Accesses at or beyond DEPTH are flagged on err.
module data_mem_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                clear_req,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable in the bound check.
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                run, clr_en, accept, wr_acc, rd_acc, in_range;
  logic [IDX_W-1:0]    addr_idx, clr_idx;

  logic                rd1_valid_q, rd1_err_q, wr_err_q;
  logic [DATA_W-1:0]   rd1_data_q;
  logic                rd_valid_int, rd_err_int;
  logic [DATA_W-1:0]   rd_data_int;

  // rst gates the outputs so reset values hold from the first rst cycle on.
  assign run      = (state_q == StRun) && !rst;
  assign clr_en   = (state_q == StClear) && !rst;
  assign ready    = run;
  assign busy     = !run;
  assign accept   = run && req;
  assign wr_acc   = accept && we;
  assign rd_acc   = accept && !we;
  assign in_range = {1'b0, addr} < DEPTH_W;
  assign addr_idx = addr[IDX_W-1:0];
  assign clr_idx  = clr_addr_q[IDX_W-1:0];

  // FSM state and clear address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state: walk clr_addr to DEPTH-1, then run until clear_req.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StClear: begin
        if (clr_addr_q == LAST) begin
          state_d    = StRun;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      StRun: begin
        if (clear_req) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  // Storage: sequencer zeroes one word per cycle, otherwise byte-lane writes.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc && in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[addr_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // First read stage plus the out-of-range write flag (always one cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_valid_q <= 1'b0;
      rd1_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      rd1_data_q  <= '0;
    end else begin
      rd1_valid_q <= rd_acc;
      rd1_err_q   <= rd_acc && !in_range;
      wr_err_q    <= wr_acc && !in_range;
      if (rd_acc) rd1_data_q <= in_range ? mem[addr_idx] : '0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              rd2_valid_q, rd2_err_q;
    logic [DATA_W-1:0] rd2_data_q;

    // Optional output stage; data only moves with a valid so rdata holds.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd2_valid_q <= 1'b0;
        rd2_err_q   <= 1'b0;
        rd2_data_q  <= '0;
      end else begin
        rd2_valid_q <= rd1_valid_q;
        rd2_err_q   <= rd1_err_q;
        if (rd1_valid_q) rd2_data_q <= rd1_data_q;
      end
    end

    assign rd_valid_int = rd2_valid_q;
    assign rd_err_int   = rd2_err_q;
    assign rd_data_int  = rd2_data_q;
  end else begin : g_no_out_reg
    assign rd_valid_int = rd1_valid_q;
    assign rd_err_int   = rd1_err_q;
    assign rd_data_int  = rd1_data_q;
  end

  assign rvalid = rd_valid_int && !rst;
  assign rdata  = rst ? '0 : rd_data_int;
  assign err    = !rst && (wr_err_q || (rd_valid_int && rd_err_int));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: table of per-cycle vectors in RUN plus
// hand-written sequences for clear, latency and reset corner cases.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, req, we, clear_req;
  logic [1:0]  be;
  logic [4:0]  addr;
  logic [15:0] wdata;

  logic        ready0, rvalid0, err0, busy0;
  logic [15:0] rdata0;
  logic        ready1, rvalid1, err1, busy1;
  logic [15:0] rdata1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .clear_req(clear_req), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0),
    .err(err0), .busy(busy0)
  );

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .clear_req(clear_req), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1),
    .err(err1), .busy(busy1)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [1:0]  be;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        rvalid;
    logic [15:0] rdata;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic r, input logic q, input logic w, input logic [1:0] b,
                     input logic [4:0] a, input logic [15:0] d, input logic c);
    rst = r; req = q; we = w; be = b; addr = a; wdata = d; clear_req = c;
  endtask

  // Inputs are driven at posedge+1; outputs are sampled at posedge+3.
  task automatic settle();
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic q, input logic w, input logic [1:0] b, input logic [4:0] a,
                     input logic [15:0] d, input logic rv, input logic [15:0] rd,
                     input logic e);
    vec_t v;
    v.req = q; v.we = w; v.be = b; v.addr = a; v.wdata = d;
    v.rvalid = rv; v.rdata = rd; v.err = e;
    vq.push_back(v);
  endtask

  // Cycles 0..16 after rst drops: busy until cycle 15, ready first in cycle 16.
  task automatic check_clear(input string name);
    for (int n = 0; n <= 16; n++) begin
      drv(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
      settle();
      chk(name, {30'd0, ready0, busy0}, {30'd0, (n == 16), (n != 16)});
      adv();
    end
  endtask

  initial begin
    // Read all words, then byte lanes, out-of-range and the DEPTH boundary.
    for (int k = 0; k < 16; k++) add(1, 0, 2'b00, 5'(k), 16'h0, (k > 0), 16'h0000, 0);
    add(1, 1, 2'b11, 5'd3,  16'hABCD, 1, 16'h0000, 0);
    add(1, 1, 2'b10, 5'd3,  16'h1200, 0, 16'h0000, 0);
    add(1, 0, 2'b00, 5'd3,  16'h0000, 0, 16'h0000, 0);
    add(1, 1, 2'b00, 5'd3,  16'hFFFF, 1, 16'h12CD, 0);
    add(1, 0, 2'b00, 5'd3,  16'h0000, 0, 16'h12CD, 0);
    add(1, 1, 2'b01, 5'd3,  16'h0077, 1, 16'h12CD, 0);
    add(1, 0, 2'b00, 5'd3,  16'h0000, 0, 16'h12CD, 0);
    add(1, 1, 2'b11, 5'd20, 16'hFFFF, 1, 16'h1277, 0);
    add(1, 0, 2'b00, 5'd20, 16'h0000, 0, 16'h1277, 1);
    add(0, 0, 2'b00, 5'd0,  16'h0000, 1, 16'h0000, 1);
    add(1, 0, 2'b00, 5'd4,  16'h0000, 0, 16'h0000, 0);
    add(1, 1, 2'b11, 5'd15, 16'hBEEF, 1, 16'h0000, 0);
    add(1, 1, 2'b11, 5'd16, 16'h1111, 0, 16'h0000, 0);
    add(1, 0, 2'b00, 5'd16, 16'h0000, 0, 16'h0000, 1);
    add(1, 0, 2'b00, 5'd15, 16'h0000, 1, 16'h0000, 1);
    add(1, 0, 2'b00, 5'd0,  16'h0000, 1, 16'hBEEF, 0);
    add(1, 0, 2'b00, 5'd4,  16'h0000, 1, 16'h0000, 0);
    add(0, 0, 2'b00, 5'd0,  16'h0000, 1, 16'h0000, 0);

    // Reset values while rst is high.
    drv(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    adv();
    settle();
    chk("reset_outputs", {11'd0, ready0, busy0, rvalid0, err0, rdata0},
        {11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    adv();
    check_clear("init_clear");

    // Table-driven vectors in RUN.
    foreach (vq[i]) begin
      drv(1'b0, vq[i].req, vq[i].we, vq[i].be, vq[i].addr, vq[i].wdata, 1'b0);
      settle();
      chk($sformatf("vec%0d", i), {11'd0, ready0, busy0, rvalid0, err0, rdata0},
          {11'd0, 1'b1, 1'b0, vq[i].rvalid, vq[i].err, vq[i].rdata});
      adv();
    end

    // Latency/throughput: four back-to-back reads on both latencies.
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b1, 1'b1, 2'b11, 5'(i), 16'(16'h0010 + i), 1'b0);
      adv();
    end
    for (int j = 0; j < 7; j++) begin
      if (j < 4) drv(1'b0, 1'b1, 1'b0, 2'b00, 5'(j), 16'h0, 1'b0);
      else       drv(1'b0, 1'b0, 1'b0, 2'b00, 5'd0,  16'h0, 1'b0);
      settle();
      chk($sformatf("lat2_rvalid%0d", j), {31'd0, rvalid1}, {31'd0, (j >= 2 && j <= 5)});
      if (j >= 2) chk($sformatf("lat2_rdata%0d", j), {16'd0, rdata1},
                      {16'd0, 16'h0010 + 16'((j > 5) ? 3 : j - 2)});
      chk($sformatf("lat1_rvalid%0d", j), {31'd0, rvalid0}, {31'd0, (j >= 1 && j <= 4)});
      if (j >= 1 && j <= 4) chk($sformatf("lat1_rdata%0d", j), {16'd0, rdata0},
                                {16'd0, 16'h0010 + 16'(j - 1)});
      adv();
    end

    // clear_req with a simultaneous read; writes and clear_req during clear ignored.
    drv(1'b0, 1'b1, 1'b1, 2'b11, 5'd5, 16'h5555, 1'b0);
    adv();
    drv(1'b0, 1'b1, 1'b0, 2'b00, 5'd5, 16'h0, 1'b1);
    settle();
    chk("clr_accept", {31'd0, ready0}, 32'd1);
    adv();
    for (int n = 1; n <= 16; n++) begin
      drv(1'b0, 1'b1, 1'b1, 2'b11, 5'd5, 16'hAAAA, (n == 6));
      settle();
      chk($sformatf("clr_busy%0d", n), {29'd0, busy0, ready0, rvalid0},
          {29'd0, 1'b1, 1'b0, (n == 1)});
      if (n == 1) chk("clr_preread", {16'd0, rdata0}, {16'd0, 16'h5555});
      if (n == 2) chk("clr_preread_lat2", {15'd0, rvalid1, rdata1}, {15'd0, 1'b1, 16'h5555});
      adv();
    end
    drv(1'b0, 1'b1, 1'b0, 2'b00, 5'd5, 16'h0, 1'b0);
    settle();
    chk("clr_done", {30'd0, ready0, busy0}, {30'd0, 1'b1, 1'b0});
    adv();
    drv(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    settle();
    chk("clr_reread", {15'd0, rvalid0, rdata0}, {15'd0, 1'b1, 16'h0000});
    adv();

    // Reset mid-read cancels in-flight reads on both latencies.
    drv(1'b0, 1'b1, 1'b1, 2'b11, 5'd5, 16'h0505, 1'b0);
    adv();
    drv(1'b0, 1'b1, 1'b0, 2'b00, 5'd5, 16'h0, 1'b0);
    adv();
    drv(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    settle();
    chk("rst_midread", {11'd0, ready0, busy0, rvalid0, err0, rdata0},
        {11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    chk("rst_midread_lat2", {31'd0, rvalid1}, 32'd0);
    adv();
    drv(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    settle();
    chk("rst_midread_lat2b", {31'd0, rvalid1}, 32'd0);
    adv();

    // Reset on clear cycle 7 restarts the full clear.
    for (int n = 1; n < 7; n++) adv();
    drv(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    settle();
    chk("rst_midclear", {29'd0, ready0, busy0, rvalid0}, {29'd0, 1'b0, 1'b1, 1'b0});
    adv();
    check_clear("reclear");
    drv(1'b0, 1'b1, 1'b0, 2'b00, 5'd5, 16'h0, 1'b0);
    adv();
    drv(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    settle();
    chk("reclear_read", {15'd0, rvalid0, rdata0}, {15'd0, 1'b1, 16'h0000});
    adv();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
